// File: rtl/vga_timing_gen.sv
// XGA 1024x768 @ 60 Hz timing generator for a 65 MHz pixel clock: counters, sync, blanking, frame strobe.
// Optional macro VGA_FRAME_TICK_EN builds the frame counter and the game-tick divider.

package vga_pkg;
  localparam logic [10:0] HBLANK_START = 11'd1024;
  localparam logic [10:0] HSYNC_START  = 11'd1048;
  localparam logic [10:0] HSYNC_STOP   = 11'd1184;
  localparam logic [10:0] HBLANK_STOP  = 11'd1344;
  localparam logic [10:0] VBLANK_START = 11'd768;
  localparam logic [10:0] VSYNC_START  = 11'd771;
  localparam logic [10:0] VSYNC_STOP   = 11'd777;
  localparam logic [10:0] VBLANK_STOP  = 11'd806;
endpackage

module vga_timing_gen #(
  parameter int          FRAME_CNT_W   = 16,
  parameter int          TICK_DIV      = 1,
  parameter logic [10:0] H_BLANK_START = vga_pkg::HBLANK_START,
  parameter logic [10:0] H_SYNC_START  = vga_pkg::HSYNC_START,
  parameter logic [10:0] H_SYNC_STOP   = vga_pkg::HSYNC_STOP,
  parameter logic [10:0] H_BLANK_STOP  = vga_pkg::HBLANK_STOP,
  parameter logic [10:0] V_BLANK_START = vga_pkg::VBLANK_START,
  parameter logic [10:0] V_SYNC_START  = vga_pkg::VSYNC_START,
  parameter logic [10:0] V_SYNC_STOP   = vga_pkg::VSYNC_STOP,
  parameter logic [10:0] V_BLANK_STOP  = vga_pkg::VBLANK_STOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [10:0]            hcount,
  output logic [10:0]            vcount,
  output logic                   hblnk,
  output logic                   vblnk,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   game_tick
);

  if (TICK_DIV < 1) begin : g_tick_div_illegal
    $error("vga_timing_gen: TICK_DIV must be at least 1");
  end

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hblnk;
  logic        r_vblnk;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  logic [10:0] w_hcount_nxt;
  logic [10:0] w_vcount_nxt;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_wrap;

  // Next-state counters; the registered flags decode these so they never lag the counts.
  always_comb begin
    w_h_last     = (r_hcount == (H_BLANK_STOP - 11'd1));
    w_v_last     = (r_vcount == (V_BLANK_STOP - 11'd1));
    w_frame_wrap = w_h_last && w_v_last;
    if (w_h_last) begin
      w_hcount_nxt = 11'd0;
    end else begin
      w_hcount_nxt = r_hcount + 11'd1;
    end
    if (!w_h_last) begin
      w_vcount_nxt = r_vcount;
    end else if (w_v_last) begin
      w_vcount_nxt = 11'd0;
    end else begin
      w_vcount_nxt = r_vcount + 11'd1;
    end
  end

  // Timing registers: counters, sync/blank flags and the frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hblnk       <= (w_hcount_nxt >= H_BLANK_START);
      r_vblnk       <= (w_vcount_nxt >= V_BLANK_START);
      r_hsync       <= (w_hcount_nxt >= H_SYNC_START) && (w_hcount_nxt < H_SYNC_STOP);
      r_vsync       <= (w_vcount_nxt >= V_SYNC_START) && (w_vcount_nxt < V_SYNC_STOP);
      r_frame_start <= w_frame_wrap;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_TICK_EN
  localparam int              DIV_W    = $clog2(TICK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [DIV_W-1:0]       r_div;
  logic                   r_game_tick;

  // Frame counter and divider step on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= {FRAME_CNT_W{1'b0}};
      r_div       <= {DIV_W{1'b0}};
      r_game_tick <= 1'b0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      if (r_div == DIV_LAST) begin
        r_div       <= {DIV_W{1'b0}};
        r_game_tick <= 1'b1;
      end else begin
        r_div       <= r_div + DIV_W'(1);
        r_game_tick <= 1'b0;
      end
    end else begin
      r_game_tick <= 1'b0;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign game_tick = r_game_tick;
`else
  assign frame_cnt = {FRAME_CNT_W{1'b0}};
  assign game_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size XGA instance for line timing, plus a shrunken-geometry instance
// (24 clocks x 10 lines, TICK_DIV=3) for frame wrap, divider and mid-frame reset.

module tb_vga_timing_gen;

  localparam int S_HT    = 24;
  localparam int S_VT    = 10;
  localparam int S_FRAME = S_HT * S_VT;

  logic clk = 1'b0;
  logic rst_n_full;
  logic rst_n_small;

  logic [10:0] f_hcount, f_vcount;
  logic        f_hblnk, f_vblnk, f_hsync, f_vsync, f_frame_start, f_game_tick;
  logic [15:0] f_frame_cnt;

  logic [10:0] s_hcount, s_vcount;
  logic        s_hblnk, s_vblnk, s_hsync, s_vsync, s_frame_start, s_game_tick;
  logic [2:0]  s_frame_cnt;
  logic [30:0] s_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int s_tick_n, s_vs_n, s_vb_n, s_fs_n;

  always #5 clk = ~clk;

  vga_timing_gen #(.FRAME_CNT_W(16), .TICK_DIV(1)) u_full (
    .clk(clk), .rst_n(rst_n_full),
    .hcount(f_hcount), .vcount(f_vcount),
    .hblnk(f_hblnk), .vblnk(f_vblnk), .hsync(f_hsync), .vsync(f_vsync),
    .frame_start(f_frame_start), .frame_cnt(f_frame_cnt), .game_tick(f_game_tick)
  );

  vga_timing_gen #(
    .FRAME_CNT_W(3), .TICK_DIV(3),
    .H_BLANK_START(11'd16), .H_SYNC_START(11'd18), .H_SYNC_STOP(11'd22), .H_BLANK_STOP(11'd24),
    .V_BLANK_START(11'd6),  .V_SYNC_START(11'd7),  .V_SYNC_STOP(11'd9),  .V_BLANK_STOP(11'd10)
  ) u_small (
    .clk(clk), .rst_n(rst_n_small),
    .hcount(s_hcount), .vcount(s_vcount),
    .hblnk(s_hblnk), .vblnk(s_vblnk), .hsync(s_hsync), .vsync(s_vsync),
    .frame_start(s_frame_start), .frame_cnt(s_frame_cnt), .game_tick(s_game_tick)
  );

  assign s_vec = {s_hcount, s_vcount, s_hblnk, s_vblnk, s_hsync, s_vsync,
                  s_frame_start, s_game_tick, s_frame_cnt};

  typedef struct {
    int          edge_n;
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        fs;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected small-instance outputs e edges after reset release.
  function automatic logic [30:0] small_exp(input int e);
    int         h, v, fr;
    logic       fs, gt;
    logic [2:0] fc;
    h  = e % S_HT;
    v  = (e / S_HT) % S_VT;
    fr = e / S_FRAME;
    fs = (e > 0) && (h == 0) && (v == 0);
`ifdef VGA_FRAME_TICK_EN
    gt = fs && ((fr % 3) == 0);
    fc = 3'(fr % 8);
`else
    gt = 1'b0;
    fc = 3'd0;
`endif
    return {11'(h), 11'(v), (h >= 16), (v >= 6), (h >= 18 && h < 22), (v >= 7 && v < 9), fs, gt, fc};
  endfunction

  task automatic run_small(input int first, input int last);
    for (int e = first; e <= last; e++) begin
      step();
      if (s_game_tick)   s_tick_n++;
      if (s_vsync)       s_vs_n++;
      if (s_vblnk)       s_vb_n++;
      if (s_frame_start) s_fs_n++;
      check($sformatf("small_edge_%0d", e), 64'(s_vec), 64'(small_exp(e)));
    end
  endtask

  initial begin
    int k, hs_n, hb_n, fs_n, tick_n;
    rst_n_full  = 1'b0;
    rst_n_small = 1'b0;
    s_tick_n = 0; s_vs_n = 0; s_vb_n = 0; s_fs_n = 0;

    vecs[0] = '{5,    11'd5,    11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1023, 11'd1023, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1024, 11'd1024, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1047, 11'd1047, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1048, 11'd1048, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1183, 11'd1183, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1184, 11'd1184, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1343, 11'd1343, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1344, 11'd0,    11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1345, 11'd1,    11'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (10) step();
    check("full_reset", 64'({f_hcount, f_vcount, f_hblnk, f_vblnk, f_hsync, f_vsync,
                            f_frame_start, f_frame_cnt, f_game_tick}), 64'd0);
    check("small_reset", 64'(s_vec), 64'd0);

    rst_n_full = 1'b1;
    k = 0; hs_n = 0; hb_n = 0; fs_n = 0; tick_n = 0;
    for (int e = 1; e <= 1345; e++) begin
      step();
      if (f_hsync)       hs_n++;
      if (f_hblnk)       hb_n++;
      if (f_frame_start) fs_n++;
      if (f_game_tick)   tick_n++;
      if (k < 10 && vecs[k].edge_n == e) begin
        check($sformatf("full_vec_edge_%0d", e),
              64'({f_hcount, f_vcount, f_hblnk, f_vblnk, f_hsync, f_vsync, f_frame_start}),
              64'({vecs[k].h, vecs[k].v, vecs[k].hb, vecs[k].vb, vecs[k].hs, vecs[k].vs, vecs[k].fs}));
        k++;
      end
    end
    check("full_vec_count", 64'(k), 64'd10);
    check("hsync_width", 64'(hs_n), 64'd136);
    check("hblnk_width", 64'(hb_n), 64'd320);
    check("full_no_frame_pulse", 64'(fs_n + tick_n), 64'd0);
    check("full_frame_cnt", 64'(f_frame_cnt), 64'd0);

    rst_n_small = 1'b1;
    run_small(1, 7 * S_FRAME);
`ifdef VGA_FRAME_TICK_EN
    check("frame_cnt_after_7", 64'(s_frame_cnt), 64'd7);
    check("ticks_after_7", 64'(s_tick_n), 64'd2);
`else
    check("frame_cnt_after_7", 64'(s_frame_cnt), 64'd0);
    check("ticks_after_7", 64'(s_tick_n), 64'd0);
`endif
    check("frame_start_after_7", 64'(s_fs_n), 64'd7);
    check("vsync_cycles_7", 64'(s_vs_n), 64'(7 * 2 * S_HT));
    check("vblnk_cycles_7", 64'(s_vb_n), 64'(7 * 4 * S_HT));

    run_small(7 * S_FRAME + 1, 8 * S_FRAME);
    run_small(8 * S_FRAME + 1, 8 * S_FRAME + 5 * S_HT + 10);
    check("pre_reset_pos", 64'({s_hcount, s_vcount}), 64'({11'd10, 11'd5}));

    #3 rst_n_small = 1'b0;
    #1 check("async_reset", 64'(s_vec), 64'd0);
    step();
    step();
    check("held_reset", 64'(s_vec), 64'd0);
    rst_n_small = 1'b1;
    s_fs_n = 0;
    run_small(1, S_FRAME + 1);
    check("restart_frame_starts", 64'(s_fs_n), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

XGA 1024×768 @ 60 Hz timing generator clocked at 65 MHz. It produces the horizontal and vertical counters, sync strobes and blanking flags that every downstream draw stage uses (background, terrain, players, points). It also produces a frame-start strobe, a frame counter and a divided game-tick pulse, which game-logic FSMs use to step once per N frames. All timing constants come from `vga_pkg`: HBLANK/HSYNC/VBLANK/VSYNC START/STOP.

## Interface
Parameters:
- `FRAME_CNT_W`, default 16: width of `frame_cnt`.
- `TICK_DIV`, default 1: frames per `game_tick` pulse. Legal range ≥1.

Ports:
- `clk`, in, 1: 65 MHz pixel clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `hcount`, out, 11: horizontal pixel position, 0..1343.
- `vcount`, out, 11: line number, 0..805.
- `hblnk`, out, 1: high when `hcount` ≥ 1024.
- `vblnk`, out, 1: high when `vcount` ≥ 768.
- `hsync`, out, 1: active-high, 1048 ≤ `hcount` < 1184.
- `vsync`, out, 1: active-high, 771 ≤ `vcount` < 777.
- `frame_start`, out, 1: one-cycle pulse while (`hcount`,`vcount`) = (0,0) after a wrap.
- `frame_cnt`, out, FRAME_CNT_W: completed-frame counter.
- `game_tick`, out, 1: one-cycle pulse every `TICK_DIV` frames.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - All outputs and internal registers go to 0 immediately, without waiting for a clock edge.
  - This includes the tick divider.
- `hcount` update, each rising edge:
  - Increments by 1.
  - At 1343 (HBLANK_STOP−1) it wraps to 0.
- `vcount` update, on the edge where `hcount` wraps:
  - Increments by 1.
  - At 805 (VBLANK_STOP−1) it wraps to 0.
- All outputs are registered.
  - The next-state counters are computed combinationally.
  - The flags are derived from those next-state values.
  - Result: every flag is exactly coherent with the `hcount`/`vcount` values on the same cycle. There is no skew between counters and flags.
- `hblnk` and `vblnk` are asserted through the whole blanking interval, including the sync region.
- `frame_start`:
  - Asserted on the cycle whose registered counts are (0,0) after a wrap from (1343,805).
  - It is NOT asserted during or immediately after reset.
- `frame_cnt`:
  - Increments on the same edge that raises `frame_start`.
  - Wraps modulo 2^FRAME_CNT_W.
- Tick divider:
  - Internal counter `div` runs 0..TICK_DIV−1 and advances on each `frame_start` edge.
  - `game_tick` is asserted together with `frame_start` when `div` wraps to 0.
  - With `TICK_DIV`=1, `game_tick` equals `frame_start`.
- Arithmetic:
  - Counters are unsigned 11-bit with no overflow; the maximum value is 1343.
  - The divider is `$clog2(TICK_DIV+1)` bits wide.
- Reset mid-frame: the block restarts from (0,0), and the first `frame_start` follows one full frame later.

## Timing
- Line: 1344 clocks. Frame: 1344 × 806 = 1,083,264 clocks.
- Latency from `rst_n` deassertion:
  - First edge gives `hcount`=1.
  - First `frame_start` comes on edge 1,083,264.
- Output latency:
  - `hsync` rises on the edge where `hcount` becomes 1048.
  - `hsync` falls on the edge where `hcount` becomes 1184.
  - `vsync` behaves the same way on `vcount` 771 and 777.
- Every pulse output (`frame_start`, `game_tick`) is exactly one clock wide.
- Simultaneous events:
  - The hcount wrap, vcount wrap, `frame_cnt` increment and `div` update all occur on the single edge into (0,0).
  - No intermediate states are visible.

## Configuration
- Macro `VGA_FRAME_TICK_EN`.
- Defined: the `frame_cnt` register, the tick divider and `game_tick` logic are built as described above.
- Undefined:
  - `frame_cnt` is tied to 0 and `game_tick` is tied to 0. No divider registers are synthesised.
  - `frame_start` and all timing outputs are unchanged.

## Test plan
- Reset check: hold `rst_n`=0 for 10 clocks → all outputs 0. Release → after 5 edges `hcount`=5, `vcount`=0, all flags 0.
- Line wrap: run to `hcount`=1343, `vcount`=0 → next edge gives `hcount`=0, `vcount`=1.
  - `hblnk` is high from 1024 through 1343.
  - `hsync` is high exactly for `hcount` 1048..1183, a width of 136 clocks.
- Frame wrap: after 1,083,264 edges → (0,0), `frame_start`=1 for one cycle, `frame_cnt`=1.
  - `vsync` was high for lines 771..776, i.e. 6 × 1344 clocks.
  - `vblnk` was high for lines 768..805.
- Divider: `TICK_DIV`=3, run 7 frames → `game_tick` pulses only at the frame-3 and frame-6 starts, and `frame_cnt`=7.
- Async reset mid-line: at `hcount`=500, `vcount`=300, drop `rst_n` between clock edges → all outputs 0 before the next edge. Release → the next `frame_start` arrives 1,083,264 edges later.
- Macro off (`VGA_FRAME_TICK_EN` undefined): run 2 frames → `frame_start` pulses twice, while `frame_cnt` and `game_tick` stay 0 throughout.
